// File: rtl/perf_event_counter.sv
// ============================================================================
// Module      : perf_event_counter
// Description : Pipeline event counters plus one weighted accumulator, behind a
//               registered register port. Optional macro: PERF_OVF_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_event_counter #(
    parameter int NUM_EVENTS = 14,
    parameter int CNT_W      = 32
) (
    input  logic                  pj_clk,
    input  logic                  pj_reset,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  acc_valid,
    input  logic [2:0]            acc_value,
    input  logic                  reg_wr,
    input  logic                  reg_rd,
    input  logic [5:0]            reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata,
    output logic                  reg_rvalid
`ifdef PERF_OVF_IRQ_EN
    ,
    output logic                  perf_irq
`endif
);

    localparam logic [5:0] C_ADDR_CTRL = 6'h00;
    localparam logic [5:0] C_ADDR_EDGE = 6'h01;
    localparam logic [5:0] C_ADDR_OVF  = 6'h02;
    localparam logic [5:0] C_ADDR_IRQ  = 6'h03;
    localparam int         C_ADDR_CNT0 = 32;
    localparam logic [5:0] C_ADDR_ACC  = 6'(C_ADDR_CNT0 + NUM_EVENTS);

    logic [NUM_EVENTS-1:0] ev_s1_q, hist_q;
    logic                  accv_s1_q;
    logic [2:0]            accval_s1_q;

    logic                  en_q, en_d, frz_q, frz_d;
    logic [NUM_EVENTS-1:0] edge_q, edge_d;
    logic [NUM_EVENTS:0]   ovf_q, ovf_d, ovf_set;
    logic [CNT_W-1:0]      cnt_q [NUM_EVENTS];
    logic [CNT_W-1:0]      cnt_d [NUM_EVENTS];
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic [CNT_W:0]        acc_sum;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q;
    logic                  count_en, clear;
    logic [NUM_EVENTS-1:0] hit;
`ifdef PERF_OVF_IRQ_EN
    logic [NUM_EVENTS:0]   irq_mask_q, irq_mask_d;
    logic                  irq_q;
`endif

    always_comb begin
        en_d     = en_q;
        frz_d    = frz_q;
        edge_d   = edge_q;
        acc_d    = acc_q;
        ovf_set  = '0;
        rdata_d  = rdata_q;
        count_en = en_q & ~(frz_q & (|ovf_q));
        clear    = reg_wr && (reg_addr == C_ADDR_CTRL) && reg_wdata[1];
`ifdef PERF_OVF_IRQ_EN
        irq_mask_d = irq_mask_q;
        if (reg_wr && reg_addr == C_ADDR_IRQ) irq_mask_d = reg_wdata[NUM_EVENTS:0];
`endif
        // Edge-mode bits need a rising transition relative to the history flop.
        hit = count_en ? (ev_s1_q & ~(edge_q & hist_q)) : '0;

        for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (hit[i]) begin
                cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                ovf_set[i] = &cnt_q[i];
            end
            if (reg_wr && reg_addr == 6'(C_ADDR_CNT0 + i)) begin
                cnt_d[i]   = reg_wdata[CNT_W-1:0];
                ovf_set[i] = 1'b0;
            end
        end

        acc_sum = {1'b0, acc_q} + (CNT_W+1)'(accval_s1_q);
        if (count_en && accv_s1_q) begin
            acc_d               = acc_sum[CNT_W-1:0];
            ovf_set[NUM_EVENTS] = acc_sum[CNT_W];
        end
        if (reg_wr && reg_addr == C_ADDR_ACC) begin
            acc_d               = reg_wdata[CNT_W-1:0];
            ovf_set[NUM_EVENTS] = 1'b0;
        end

        ovf_d = ovf_q;
        if (reg_wr && reg_addr == C_ADDR_OVF) ovf_d = ovf_q & ~reg_wdata[NUM_EVENTS:0];
        ovf_d = ovf_d | ovf_set;

        if (reg_wr && reg_addr == C_ADDR_CTRL) begin
            en_d  = reg_wdata[0];
            frz_d = reg_wdata[2];
        end
        if (reg_wr && reg_addr == C_ADDR_EDGE) edge_d = reg_wdata[NUM_EVENTS-1:0];

        if (clear) begin
            for (int i = 0; i < NUM_EVENTS; i++) cnt_d[i] = '0;
            acc_d = '0;
            ovf_d = '0;
        end

        // Reads see pre-write state, so a same-cycle write is not visible yet.
        if (reg_rd) begin
            rdata_d = '0;
            if (reg_addr == C_ADDR_CTRL) rdata_d = {29'd0, frz_q, 1'b0, en_q};
            if (reg_addr == C_ADDR_EDGE) rdata_d = 32'(edge_q);
            if (reg_addr == C_ADDR_OVF)  rdata_d = 32'(ovf_q);
`ifdef PERF_OVF_IRQ_EN
            if (reg_addr == C_ADDR_IRQ)  rdata_d = 32'(irq_mask_q);
`endif
            for (int i = 0; i < NUM_EVENTS; i++)
                if (reg_addr == 6'(C_ADDR_CNT0 + i)) rdata_d = 32'(cnt_q[i]);
            if (reg_addr == C_ADDR_ACC)  rdata_d = 32'(acc_q);
        end
    end

    always_ff @(posedge pj_clk) begin
        if (pj_reset) begin
            ev_s1_q     <= '0;
            hist_q      <= '0;
            accv_s1_q   <= 1'b0;
            accval_s1_q <= '0;
            en_q        <= 1'b0;
            frz_q       <= 1'b0;
            edge_q      <= '0;
            ovf_q       <= '0;
            acc_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
`ifdef PERF_OVF_IRQ_EN
            irq_mask_q  <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            ev_s1_q     <= event_in;
            hist_q      <= ev_s1_q;
            accv_s1_q   <= acc_valid;
            accval_s1_q <= acc_value;
            en_q        <= en_d;
            frz_q       <= frz_d;
            edge_q      <= edge_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= reg_rd;
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= cnt_d[i];
`ifdef PERF_OVF_IRQ_EN
            irq_mask_q  <= irq_mask_d;
            irq_q       <= |(ovf_q & irq_mask_q);
`endif
        end
    end

    assign reg_rdata  = rdata_q;
    assign reg_rvalid = rvalid_q;
`ifdef PERF_OVF_IRQ_EN
    assign perf_irq   = irq_q;
`endif

endmodule

`default_nettype wire
